bus_arbiter: RTL and testbench

- Round-robin arbiter and transaction sequencer that shares the single memory DMA port among num_caches_p caches.
- Grants one cache ownership of the bus for a complete block transaction of beats_lp = block_size_p/dma_data_width_p beats.
- Forwards that owner's request beats to memory and routes read response beats back to the owner only.
- Sits between the per-core cache controllers and the memory model, as the multicore bus.

---
 rtl/bus_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_bus_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter
// Round-robin arbiter and transaction sequencer that shares one memory DMA
// port among several caches. One cache at a time owns the bus for a whole
// block transaction of beats_lp beats. The owner's request beats go to
// memory, and read response beats come back to the owner only.
//
// Ports:
//   clk_i, nreset_i       clock, asynchronous active-low reset
//   cb_valid_i/cb_yumi_o  per-cache beat request valid / beat accepted
//   cb_pkt_i              per-cache packet {addr[31:0], we, wdata}, cache i
//                         in slice [i*pw_lp +: pw_lp]
//   mem_ready_i           memory can accept a beat
//   mem_valid_o/we/addr/wdata  beat presented to memory
//   mem_valid_i/data_i    memory read response beat
//   cb_valid_o/cb_data_o  one-hot response valid to owner, broadcast data
//   busy_o                a transaction is in progress
//   owner_o               current or last owner index
//   err_o                 sticky unexpected-response flag
module bus_arbiter #(
   parameter int num_caches_p     = 2,
   parameter int block_size_p     = 8,
   parameter int dma_data_width_p = 2
) (
   input  logic                                              clk_i,
   input  logic                                              nreset_i,
   input  logic [num_caches_p-1:0]                           cb_valid_i,
   output logic [num_caches_p-1:0]                           cb_yumi_o,
   input  logic [num_caches_p*(33+32*dma_data_width_p)-1:0]  cb_pkt_i,
   input  logic                                              mem_ready_i,
   output logic                                              mem_valid_o,
   output logic                                              mem_we_o,
   output logic [31:0]                                       mem_addr_o,
   output logic [32*dma_data_width_p-1:0]                    mem_wdata_o,
   input  logic                                              mem_valid_i,
   input  logic [32*dma_data_width_p-1:0]                    mem_data_i,
   output logic [num_caches_p-1:0]                           cb_valid_o,
   output logic [32*dma_data_width_p-1:0]                    cb_data_o,
   output logic                                              busy_o,
   output logic [((num_caches_p > 1) ? $clog2(num_caches_p) : 1)-1:0] owner_o,
   output logic                                              err_o
);

   localparam int beats_lp = block_size_p / dma_data_width_p;
   localparam int dw_lp    = 32 * dma_data_width_p;
   localparam int pw_lp    = 33 + dw_lp;
   localparam int ow_lp    = (num_caches_p > 1) ? $clog2(num_caches_p) : 1;
   localparam int cw_lp    = $clog2(beats_lp + 1);

   localparam logic [cw_lp-1:0] beatsC = cw_lp'(beats_lp);
   localparam logic [cw_lp-1:0] lastC  = cw_lp'(beats_lp - 1);
   localparam logic [ow_lp-1:0] maxIdxC = ow_lp'(num_caches_p - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      RECV = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [ow_lp-1:0] owner_q, owner_d;
   logic [ow_lp-1:0] ptr_q, ptr_d;
   logic [cw_lp-1:0] tx_q, tx_d;
   logic [cw_lp-1:0] rx_q, rx_d;
   logic             we_q, we_d;
   logic             err_q, err_d;

   logic [pw_lp-1:0] ownerPkt;
   logic [31:0]      pktAddr;
   logic             pktWe;
   logic [dw_lp-1:0] pktWdata;
   logic             ownerValid;
   logic             accept;
   logic             respOk;
   logic [cw_lp-1:0] rxNext;
   logic             weNow;
   logic [ow_lp-1:0] winner;
   logic             found;

   assign ownerPkt   = cb_pkt_i[int'(owner_q)*pw_lp +: pw_lp];
   assign pktAddr    = ownerPkt[pw_lp-1 -: 32];
   assign pktWe      = ownerPkt[dw_lp];
   assign pktWdata   = ownerPkt[dw_lp-1:0];
   assign ownerValid = cb_valid_i[owner_q];

   assign accept = (state_q == SEND) & ownerValid & mem_ready_i;

   // A response is only legitimate once the first beat of a read has been
   // accepted (tx_q != 0 makes we_q meaningful) and not all beats are back yet.
   assign respOk = mem_valid_i & (state_q != IDLE) & (tx_q != '0) & ~we_q
                   & (rx_q != beatsC);
   assign rxNext = rx_q + cw_lp'(respOk);

   // On the first beat we_q is not yet latched, so direction comes from the packet.
   assign weNow = (tx_q == '0) ? pktWe : we_q;

   // First requester at or after the round-robin pointer, wrapping around.
   always_comb begin
      winner = ptr_q;
      found  = 1'b0;
      for (int k = 0; k < num_caches_p; k++) begin
         if (!found && cb_valid_i[(int'(ptr_q) + k) % num_caches_p]) begin
            winner = ow_lp'((int'(ptr_q) + k) % num_caches_p);
            found  = 1'b1;
         end
      end
   end

   // Next-state logic for the transaction FSM and its counters.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      tx_d    = tx_q;
      rx_d    = rxNext;
      we_d    = we_q;
      err_d   = err_q | (mem_valid_i & ~respOk);

      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = SEND;
               owner_d = winner;
               ptr_d   = (winner == maxIdxC) ? '0 : winner + ow_lp'(1);
            end
         end
         SEND: begin
            if (accept) begin
               tx_d = tx_q + cw_lp'(1);
               if (tx_q == '0) begin
                  we_d = pktWe;
               end
               if (tx_q == lastC) begin
                  if (weNow || (rxNext == beatsC)) begin
                     state_d = IDLE;
                  end else begin
                     state_d = RECV;
                  end
               end
            end
         end
         RECV: begin
            if (rxNext == beatsC) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_d == IDLE) begin
         tx_d = '0;
         rx_d = '0;
      end
   end

   // Per-cache handshake outputs go to the owner only.
   always_comb begin
      cb_yumi_o           = '0;
      cb_valid_o          = '0;
      cb_yumi_o[owner_q]  = accept;
      cb_valid_o[owner_q] = respOk;
   end

   assign mem_valid_o = (state_q == SEND) & ownerValid;
   assign mem_we_o    = mem_valid_o & pktWe;
   assign mem_addr_o  = mem_valid_o ? pktAddr : '0;
   assign mem_wdata_o = mem_valid_o ? pktWdata : '0;
   assign cb_data_o   = mem_data_i;
   assign busy_o      = (state_q != IDLE);
   assign owner_o     = owner_q;
   assign err_o       = err_q;

   // State registers.
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         we_q    <= we_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
// Directed, table-driven bench for bus_arbiter with two caches and four
// beats per block. Each table row is one clock cycle of inputs plus the
// outputs expected in that cycle; a short hand-written sequence covers
// reset in the middle of a read.
module tb_bus_arbiter;

   localparam int N  = 2;
   localparam int DW = 64;
   localparam int PW = 33 + DW;

   logic          clk;
   logic          rstN;
   logic [N-1:0]  cbValidI;
   logic [N-1:0]  cbYumiO;
   logic [N*PW-1:0] cbPktI;
   logic          memReadyI;
   logic          memValidO;
   logic          memWeO;
   logic [31:0]   memAddrO;
   logic [DW-1:0] memWdataO;
   logic          memValidI;
   logic [DW-1:0] memDataI;
   logic [N-1:0]  cbValidO;
   logic [DW-1:0] cbDataO;
   logic          busyO;
   logic [0:0]    ownerO;
   logic          errO;

   bus_arbiter #(.num_caches_p(2), .block_size_p(8), .dma_data_width_p(2)) dut (
      .clk_i      (clk),
      .nreset_i   (rstN),
      .cb_valid_i (cbValidI),
      .cb_yumi_o  (cbYumiO),
      .cb_pkt_i   (cbPktI),
      .mem_ready_i(memReadyI),
      .mem_valid_o(memValidO),
      .mem_we_o   (memWeO),
      .mem_addr_o (memAddrO),
      .mem_wdata_o(memWdataO),
      .mem_valid_i(memValidI),
      .mem_data_i (memDataI),
      .cb_valid_o (cbValidO),
      .cb_data_o  (cbDataO),
      .busy_o     (busyO),
      .owner_o    (ownerO),
      .err_o      (errO)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [1:0] valid;
      logic       we;
      logic       ready;
      logic       memValid;
      logic [1:0] expYumi;
      logic       expMemValid;
      logic       expBusy;
      logic       expOwner;
      logic [1:0] expCbValid;
      logic       expErr;
   } vec_t;

   vec_t vecs[$];
   int   vectors;
   int   miscompares;

   logic [31:0]   addrOf [2];
   logic [DW-1:0] wdataOf[2];
   logic [DW-1:0] respData;

   task automatic addVec(input string name, input logic [1:0] valid, input logic we,
                         input logic ready, input logic memValid,
                         input logic [1:0] expYumi, input logic expMemValid,
                         input logic expBusy, input logic expOwner,
                         input logic [1:0] expCbValid, input logic expErr);
      vec_t v;
      v.name = name; v.valid = valid; v.we = we; v.ready = ready;
      v.memValid = memValid; v.expYumi = expYumi; v.expMemValid = expMemValid;
      v.expBusy = expBusy; v.expOwner = expOwner; v.expCbValid = expCbValid;
      v.expErr = expErr;
      vecs.push_back(v);
   endtask

   task automatic checkOutput(input string name, input string field,
                              input logic [63:0] actual, input logic [63:0] expected);
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s %s: got %0h expected %0h", name, field, actual, expected);
      end
   endtask

   task automatic setPackets(input logic we);
      cbPktI = {addrOf[1], we, wdataOf[1], addrOf[0], we, wdataOf[0]};
   endtask

   // Full output check against a row's expectations.
   task automatic checkAll(input vec_t v);
      logic [31:0]   eAddr;
      logic [DW-1:0] eWdata;
      eAddr  = v.expMemValid ? addrOf[v.expOwner]  : 32'h0;
      eWdata = v.expMemValid ? wdataOf[v.expOwner] : '0;
      checkOutput(v.name, "yumi",      64'(cbYumiO),   64'(v.expYumi));
      checkOutput(v.name, "mem_valid", 64'(memValidO), 64'(v.expMemValid));
      checkOutput(v.name, "mem_we",    64'(memWeO),    64'(v.expMemValid & v.we));
      checkOutput(v.name, "mem_addr",  64'(memAddrO),  64'(eAddr));
      checkOutput(v.name, "mem_wdata", memWdataO,      eWdata);
      checkOutput(v.name, "busy",      64'(busyO),     64'(v.expBusy));
      checkOutput(v.name, "owner",     64'(ownerO),    64'(v.expOwner));
      checkOutput(v.name, "cb_valid",  64'(cbValidO),  64'(v.expCbValid));
      checkOutput(v.name, "cb_data",   cbDataO,        respData);
      checkOutput(v.name, "err",       64'(errO),      64'(v.expErr));
   endtask

   // Drive one row mid-cycle and check outputs just after.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      cbValidI  = v.valid;
      memReadyI = v.ready;
      memValidI = v.memValid;
      setPackets(v.we);
      #1;
      checkAll(v);
      vectors++;
   endtask

   initial begin
      vec_t r;
      vectors     = 0;
      miscompares = 0;
      addrOf[0]   = 32'hA000_0040;
      addrOf[1]   = 32'hB000_0080;
      wdataOf[0]  = 64'h0123_4567_89AB_CDEF;
      wdataOf[1]  = 64'hFEDC_BA98_7654_3210;
      respData    = 64'h5555_AAAA_1234_5678;
      memDataI    = respData;
      rstN        = 1'b0;
      cbValidI    = 2'b11;
      memReadyI   = 1'b1;
      memValidI   = 1'b1;
      setPackets(1'b0);

      // Single read by cache0: arbitration, 4 accepts, 4 responses.
      addVec("rd_arb", 2'b01, 0, 1, 0, 2'b00, 0, 0, 0, 2'b00, 0);
      for (int i = 0; i < 4; i++) addVec($sformatf("rd_beat%0d", i), 2'b01, 0, 1, 0, 2'b01, 1, 1, 0, 2'b00, 0);
      for (int i = 0; i < 4; i++) addVec($sformatf("rd_resp%0d", i), 2'b00, 0, 1, 1, 2'b00, 0, 1, 0, 2'b01, 0);
      addVec("rd_done", 2'b00, 0, 1, 0, 2'b00, 0, 0, 0, 2'b00, 0);
      // Both caches request writes continuously; pointer is 1 after cache0's grant.
      addVec("rr_arb_a", 2'b11, 1, 1, 0, 2'b00, 0, 0, 0, 2'b00, 0);
      for (int i = 0; i < 4; i++) addVec($sformatf("rr_c1_%0d", i), 2'b11, 1, 1, 0, 2'b10, 1, 1, 1, 2'b00, 0);
      addVec("rr_arb_b", 2'b11, 1, 1, 0, 2'b00, 0, 0, 1, 2'b00, 0);
      for (int i = 0; i < 4; i++) addVec($sformatf("rr_c0_%0d", i), 2'b11, 1, 1, 0, 2'b01, 1, 1, 0, 2'b00, 0);
      addVec("rr_arb_c", 2'b11, 1, 1, 0, 2'b00, 0, 0, 0, 2'b00, 0);
      for (int i = 0; i < 4; i++) addVec($sformatf("rr_c1b_%0d", i), 2'b11, 1, 1, 0, 2'b10, 1, 1, 1, 2'b00, 0);
      addVec("rr_idle", 2'b00, 1, 1, 0, 2'b00, 0, 0, 1, 2'b00, 0);
      // Cache1 write with ready toggling; completes straight to IDLE.
      addVec("wbp_arb", 2'b10, 1, 1, 0, 2'b00, 0, 0, 1, 2'b00, 0);
      for (int i = 0; i < 7; i++) begin
         if (i % 2 == 0) addVec($sformatf("wbp_rdy%0d", i), 2'b10, 1, 1, 0, 2'b10, 1, 1, 1, 2'b00, 0);
         else            addVec($sformatf("wbp_stall%0d", i), 2'b10, 1, 0, 0, 2'b00, 1, 1, 1, 2'b00, 0);
      end
      addVec("wbp_done", 2'b00, 1, 1, 0, 2'b00, 0, 0, 1, 2'b00, 0);
      // Pipelined read: all responses arrive before the last accept, so no RECV.
      addVec("prd_arb",   2'b01, 0, 1, 0, 2'b00, 0, 0, 1, 2'b00, 0);
      addVec("prd_b0",    2'b01, 0, 1, 0, 2'b01, 1, 1, 0, 2'b00, 0);
      addVec("prd_b1",    2'b01, 0, 1, 1, 2'b01, 1, 1, 0, 2'b01, 0);
      addVec("prd_b2",    2'b01, 0, 1, 1, 2'b01, 1, 1, 0, 2'b01, 0);
      addVec("prd_hold0", 2'b01, 0, 0, 1, 2'b00, 1, 1, 0, 2'b01, 0);
      addVec("prd_hold1", 2'b01, 0, 0, 1, 2'b00, 1, 1, 0, 2'b01, 0);
      addVec("prd_b3",    2'b01, 0, 1, 0, 2'b01, 1, 1, 0, 2'b00, 0);
      addVec("prd_idle",  2'b00, 0, 1, 0, 2'b00, 0, 0, 0, 2'b00, 0);
      // Spurious response in IDLE sets the sticky error.
      addVec("spur",      2'b00, 0, 1, 1, 2'b00, 0, 0, 0, 2'b00, 0);
      addVec("spur_hold0",2'b00, 0, 1, 0, 2'b00, 0, 0, 0, 2'b00, 1);
      addVec("spur_hold1",2'b00, 0, 1, 0, 2'b00, 0, 0, 0, 2'b00, 1);
      // Read by cache0 reaching RECV with two responses back, then reset.
      addVec("rr2_arb", 2'b01, 0, 1, 0, 2'b00, 0, 0, 0, 2'b00, 1);
      for (int i = 0; i < 4; i++) addVec($sformatf("rr2_beat%0d", i), 2'b01, 0, 1, 0, 2'b01, 1, 1, 0, 2'b00, 1);
      for (int i = 0; i < 2; i++) addVec($sformatf("rr2_resp%0d", i), 2'b00, 0, 1, 1, 2'b00, 0, 1, 0, 2'b01, 1);

      // Reset state with requests and a response pending on the inputs.
      @(negedge clk);
      #1;
      r.name = "reset"; r.valid = 2'b11; r.we = 0; r.ready = 1; r.memValid = 1;
      r.expYumi = 2'b00; r.expMemValid = 0; r.expBusy = 0; r.expOwner = 0;
      r.expCbValid = 2'b00; r.expErr = 0;
      checkAll(r);
      vectors++;
      @(negedge clk);
      memValidI = 1'b0;
      cbValidI  = 2'b00;
      rstN      = 1'b1;

      foreach (vecs[i]) applyStimulus(vecs[i]);

      // Reset asserted mid-RECV: outputs clear without waiting for a clock.
      @(negedge clk);
      cbValidI  = 2'b01;
      memValidI = 1'b1;
      #2;
      rstN = 1'b0;
      #1;
      r.name = "mid_reset"; r.valid = 2'b01; r.we = 0; r.ready = 1; r.memValid = 1;
      r.expYumi = 2'b00; r.expMemValid = 0; r.expBusy = 0; r.expOwner = 0;
      r.expCbValid = 2'b00; r.expErr = 0;
      checkAll(r);
      vectors++;
      @(negedge clk);
      memValidI = 1'b0;
      cbValidI  = 2'b00;
      rstN      = 1'b1;

      // Pointer is back at 0, but only cache1 requests, so cache1 wins.
      r.name = "post_arb"; r.valid = 2'b10; r.we = 0; r.ready = 1; r.memValid = 0;
      r.expYumi = 2'b00; r.expMemValid = 0; r.expBusy = 0; r.expOwner = 0;
      r.expCbValid = 2'b00; r.expErr = 0;
      applyStimulus(r);
      r.name = "post_grant"; r.expYumi = 2'b10; r.expMemValid = 1; r.expBusy = 1;
      r.expOwner = 1;
      applyStimulus(r);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
